// File: rtl/uart_tx_ctrl_fsm.sv
// UART transmit sequencer: frames start/data/parity/stop bits with an internal baud prescaler.
// Optional macro UART_TX_STOP2_EN selects two stop bit periods instead of one.
module uart_tx_ctrl_fsm #(
    parameter int unsigned DATA_SIZE      = 8,
    parameter int unsigned PRESCALE_WIDTH = 8
) (
    input  logic                      CLK_FSM,
    input  logic                      RST_FSM,
    input  logic                      Data_valid_FSM,
    input  logic                      PAR_EN_FSM,
    input  logic [PRESCALE_WIDTH-1:0] PRESCALE_FSM,
    output logic                      ser_load_FSM,
    output logic                      par_load_FSM,
    output logic                      ser_shift_FSM,
    output logic [1:0]                mux_sel_FSM,
    output logic                      busy_FSM
);

    localparam int unsigned BIT_W = $clog2(DATA_SIZE);

    localparam logic [1:0] MUX_START  = 2'b00;
    localparam logic [1:0] MUX_DATA   = 2'b01;
    localparam logic [1:0] MUX_PARITY = 2'b10;
    localparam logic [1:0] MUX_STOP   = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    state_e                    state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] baud_q, baud_d;
    logic [BIT_W-1:0]          bit_q, bit_d;
    logic                      par_en_q, par_en_d;
    logic [1:0]                mux_q, mux_d;
    logic                      busy_q, busy_d;

    logic [PRESCALE_WIDTH-1:0] prescale_eff;
    logic                      tick;
    logic                      last_bit;
    logic                      stop_done;
    logic                      accept;

    // A prescale of zero behaves like one cycle per bit.
    assign prescale_eff = (PRESCALE_FSM == '0) ? PRESCALE_WIDTH'(1) : PRESCALE_FSM;
    assign tick         = (baud_q == (prescale_eff - PRESCALE_WIDTH'(1)));
    assign last_bit     = (bit_q == BIT_W'(DATA_SIZE - 1));

`ifdef UART_TX_STOP2_EN
    assign stop_done = (bit_q == BIT_W'(1));
`else
    assign stop_done = 1'b1;
`endif

    // New frame accepted from IDLE or on the final STOP tick.
    assign accept = Data_valid_FSM && !RST_FSM &&
                    ((state_q == IDLE) || ((state_q == STOP) && tick && stop_done));

    // State register
    always_ff @(posedge CLK_FSM) begin
        if (RST_FSM) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            par_en_q <= 1'b0;
            mux_q    <= MUX_STOP;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            par_en_q <= par_en_d;
            mux_q    <= mux_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        par_en_d = par_en_q;
        baud_d   = ((state_q == IDLE) || tick) ? '0 : (baud_q + PRESCALE_WIDTH'(1));

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = START;
                    par_en_d = PAR_EN_FSM;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (last_bit) begin
                        state_d = par_en_q ? PARITY : STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    bit_d   = '0;
                end
            end
            STOP: begin
                if (tick) begin
                    if (stop_done) begin
                        bit_d = '0;
                        if (accept) begin
                            state_d  = START;
                            par_en_d = PAR_EN_FSM;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                bit_d   = '0;
            end
        endcase
    end

    // Output logic: pulses are combinational, mux/busy follow the next state
    always_comb begin
        ser_load_FSM  = accept;
        par_load_FSM  = accept;
        ser_shift_FSM = (state_q == DATA) && tick && !last_bit && !RST_FSM;
        busy_d        = (state_d != IDLE);
        mux_d         = MUX_STOP;
        case (state_d)
            START:   mux_d = MUX_START;
            DATA:    mux_d = MUX_DATA;
            PARITY:  mux_d = MUX_PARITY;
            default: mux_d = MUX_STOP;
        endcase
    end

    assign mux_sel_FSM = mux_q;
    assign busy_FSM    = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl_fsm.sv
// Scoreboard bench for uart_tx_ctrl_fsm: expected line segments are queued by the stimulus
// and checked by a monitor that splits the observed (mux_sel, busy) stream into runs.
module tb_uart_tx_ctrl_fsm;

    localparam int unsigned DATA_SIZE = 8;
    localparam int unsigned PW        = 8;
`ifdef UART_TX_STOP2_EN
    localparam int STOP_BITS = 2;
`else
    localparam int STOP_BITS = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          dv;
    logic          par_en;
    logic [PW-1:0] prescale;
    logic          ser_load, par_load, ser_shift, busy;
    logic [1:0]    mux_sel;

    uart_tx_ctrl_fsm #(.DATA_SIZE(DATA_SIZE), .PRESCALE_WIDTH(PW)) dut (
        .CLK_FSM       (clk),
        .RST_FSM       (rst),
        .Data_valid_FSM(dv),
        .PAR_EN_FSM    (par_en),
        .PRESCALE_FSM  (prescale),
        .ser_load_FSM  (ser_load),
        .par_load_FSM  (par_load),
        .ser_shift_FSM (ser_shift),
        .mux_sel_FSM   (mux_sel),
        .busy_FSM      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mux;
        int busy;
        int len;     // 0 = length not checked (idle runs)
        int shifts;
        int loads;
    } seg_t;

    seg_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;

    int cur_mux, cur_busy, cur_len, cur_sh, cur_ld, cur_pld;
    int seg_idx = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_seg(input int m, input int b, input int len, input int sh, input int ld);
        seg_t s;
        s.mux = m; s.busy = b; s.len = len; s.shifts = sh; s.loads = ld;
        exp_q.push_back(s);
    endtask

    task automatic push_frame(input int p, input bit par, input int stop_loads);
        push_seg(0, 1, p, 0, 0);
        push_seg(1, 1, DATA_SIZE * p, DATA_SIZE - 1, 0);
        if (par) push_seg(2, 1, p, 0, 0);
        push_seg(3, 1, STOP_BITS * p, 0, stop_loads);
    endtask

    task automatic close_seg();
        seg_t e;
        string tag;
        tag = $sformatf("seg%0d", seg_idx);
        seg_idx++;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s unexpected: mux %0d busy %0d len %0d, expected no segment",
                     tag, cur_mux, cur_busy, cur_len);
        end else begin
            e = exp_q.pop_front();
            check({tag, " mux_sel"}, cur_mux, e.mux);
            check({tag, " busy"}, cur_busy, e.busy);
            if (e.len != 0) check({tag, " length"}, cur_len, e.len);
            check({tag, " ser_shift count"}, cur_sh, e.shifts);
            check({tag, " ser_load count"}, cur_ld, e.loads);
            check({tag, " par_load count"}, cur_pld, e.loads);
        end
        cur_len = 0;
    endtask

    // Monitor: sample away from the active edge, close a run whenever mux/busy changes
    always @(negedge clk) begin
        if (mon_en) begin
            if (cur_len > 0 && (int'(mux_sel) != cur_mux || int'(busy) != cur_busy))
                close_seg();
            if (cur_len == 0) begin
                cur_mux  = int'(mux_sel);
                cur_busy = int'(busy);
                cur_sh   = 0;
                cur_ld   = 0;
                cur_pld  = 0;
            end
            cur_len++;
            if (ser_shift) cur_sh++;
            if (ser_load)  cur_ld++;
            if (par_load)  cur_pld++;
        end
    end

    task automatic send(input bit par, input int pre);
        @(posedge clk);
        #1 dv = 1'b1; par_en = par; prescale = PW'(pre);
        @(posedge clk);
        #1 dv = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time expired, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; dv = 1'b0; par_en = 1'b0; prescale = PW'(4);

        // Reset state, including a request presented while reset is held
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reset mux_sel", int'(mux_sel), 3);
            check("reset busy", int'(busy), 0);
            check("reset ser_load", int'(ser_load), 0);
            check("reset par_load", int'(par_load), 0);
            check("reset ser_shift", int'(ser_shift), 0);
            dv = 1'b1;
        end
        @(posedge clk);
        #1 rst = 1'b0; dv = 1'b0;
        mon_en = 1'b1;
        wait_cyc(5);

        // Frame without parity, P=4
        push_seg(3, 0, 0, 0, 1);
        push_frame(4, 1'b0, 0);
        send(1'b0, 4);
        wait_cyc(60);

        // Frame with parity; PAR_EN dropped during DATA must not remove PARITY
        push_seg(3, 0, 0, 0, 1);
        push_frame(4, 1'b1, 0);
        send(1'b1, 4);
        wait_cyc(10);
        #1 par_en = 1'b0;
        wait_cyc(60);

        // Back-to-back frames with Data_valid held through the first frame
        push_seg(3, 0, 0, 0, 1);
        push_frame(4, 1'b0, 1);
        push_frame(4, 1'b0, 0);
        @(posedge clk);
        #1 dv = 1'b1; par_en = 1'b0; prescale = PW'(4);
        repeat ((DATA_SIZE + 1 + STOP_BITS) * 4 + 1) @(posedge clk);
        #1 dv = 1'b0;
        wait_cyc(60);

        // PRESCALE=0 behaves as one cycle per bit
        push_seg(3, 0, 0, 0, 1);
        push_frame(1, 1'b0, 0);
        send(1'b0, 0);
        wait_cyc(20);

        // Odd prescale with parity
        push_seg(3, 0, 0, 0, 1);
        push_frame(3, 1'b1, 0);
        send(1'b1, 3);
        wait_cyc(50);

        // Reset during DATA bit 3 (14th DATA cycle), then a full frame
        push_seg(3, 0, 0, 0, 1);
        push_seg(0, 1, 4, 0, 0);
        push_seg(1, 1, 14, 3, 0);
        send(1'b0, 4);
        wait_cyc(17);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post-reset mux_sel", int'(mux_sel), 3);
        check("post-reset busy", int'(busy), 0);
        wait_cyc(3);
        push_seg(3, 0, 0, 0, 1);
        push_frame(4, 1'b0, 0);
        send(1'b0, 4);
        wait_cyc(60);

        check("scoreboard leftover segments", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
